hfence_seq: RTL and testbench
=============================

# hfence_seq

Sequences HFENCE.VVMA and HFENCE.GVMA by walking the shared TLB one entry per cycle and invalidating guest entries that match the latched VMID, ASID and address operands. Sits beside the hypervisor CSR file in the privileged unit. Reads the current VMID from hgatp, stalls the M stage while a fence is in flight, and drives the TLB invalidate port.

## Interface
Parameters:
- P — cvw_t configuration; supplies XLEN.
- ENTRIES — default 32; number of TLB entries; power of two, ≥2.

Ports:
- clk  in  1  — clock.
- reset  in  1  — synchronous, active-low.
- HFenceVVMAM  in  1  — HFENCE.VVMA in M stage, already validated legal.
- HFenceGVMAM  in  1  — HFENCE.GVMA in M stage, already validated legal.
- FenceRs1M  in  XLEN  — rs1 value (guest virtual address for VVMA).
- FenceRs2M  in  XLEN  — rs2 value (ASID for VVMA, VMID for GVMA).
- Rs1ZeroM  in  1  — rs1 field is x0.
- Rs2ZeroM  in  1  — rs2 field is x0.
- HGATP_REGW  in  XLEN  — current hgatp.
- TLBBusy  in  1  — TLB is mid-fill; the walk must pause.
- EntryValid  in  1  — valid bit of entry EntryIdx.
- EntryVirt  in  1  — entry belongs to a guest (V=1) translation.
- EntryGlobal  in  1  — G bit of entry.
- EntryVMID  in  VMIDW  — VMID tag of entry.
- EntryASID  in  ASIDW  — ASID tag of entry.
- EntryVPN  in  VPNW  — VPN tag of entry.
- EntryIdx  out  log2(ENTRIES)  — entry being inspected.
- EntryInvalidate  out  1  — clear entry EntryIdx this cycle.
- FlushAllVirt  out  1  — one-cycle bulk clear of all EntryVirt entries.
- FenceStallM  out  1  — hold M stage.
- FenceDoneM  out  1  — one-cycle completion pulse.

## Operation
- States: IDLE, WAIT, SCAN, FLUSH, DONE.
- IDLE: when a request is seen, latch the operation type, rs1 VPN, rs2 low bits and both zero flags.
  - For VVMA, also latch hgatp.VMID.
  - If both HFenceVVMAM and HFenceGVMAM are high, GVMA wins.
- Next state from IDLE:
  - FLUSH if Rs1ZeroM & Rs2ZeroM & GVMA.
  - Otherwise WAIT if TLBBusy, else SCAN.
- WAIT → SCAN when TLBBusy falls.
- SCAN: index starts at 0 and advances by 1 per cycle in which TLBBusy=0.
  - While TLBBusy=1, the index holds and EntryInvalidate is forced to 0.
  - After index ENTRIES-1 is processed, go to DONE (no wrap).
- FLUSH: assert FlushAllVirt for one cycle, then go to DONE.
- DONE: pulse FenceDoneM, then return to IDLE.
- Match rule for VVMA; EntryInvalidate = EntryValid & EntryVirt & all of:
  - EntryVMID == latched hgatp.VMID;
  - rs1 is x0, or EntryVPN == latched VPN;
  - rs2 is x0, or (~EntryGlobal and EntryASID == latched ASID).
- Match rule for GVMA; EntryInvalidate = EntryValid & EntryVirt & (rs2 is x0, or EntryVMID == latched VMID).
  - The rs1 guest-physical address is deliberately ignored: the TLB caches combined two-stage translations, so over-invalidation is required.
- Non-virtual entries (EntryVirt=0) are never invalidated.
- Requests arriving while not in IDLE are ignored; the pipeline is stalled, so none are legal.
- Reset mid-operation: go to IDLE with all outputs 0, and produce no FenceDoneM.

## Timing
- Reset values: EntryIdx=0, EntryInvalidate=0, FlushAllVirt=0, FenceStallM=0, FenceDoneM=0.
- FenceStallM:
  - Combinationally high in IDLE when a request is present.
  - Registered high through WAIT, SCAN and FLUSH.
  - Low in DONE.
- Scan latency with no busy: request at cycle N; SCAN covers N+1..N+ENTRIES; DONE at N+ENTRIES+1.
  - Stall covers ENTRIES+1 cycles.
  - Each TLBBusy cycle adds exactly one cycle.
- Flush latency: FLUSH at N+1, DONE at N+2.
- EntryInvalidate is combinational from the registered index and the Entry* inputs, valid in the same cycle.

## Structure
- Shared package constants:
  - VMIDW = 14 for RV64, 7 for RV32 (hgatp[57:44] / hgatp[28:22]).
  - ASIDW = 16 for RV64, 9 for RV32.
  - VPNW.
  - hfence_state_t enum.
- Sub-module hfence_match holds the combinational match rule. It is reused later for SFENCE.VMA under V=1.

## Test plan
- VVMA with rs1=x0, rs2=x0, hgatp.VMID=5, ENTRIES=32; entries 3 and 9 virtual with VMID 5, entry 4 VMID 6 → invalidate at idx 3 and 9 only; FenceDoneM at N+33.
- VVMA with rs2=ASID 0x12; entry 7 has ASID 0x12 and G=1, entry 8 has ASID 0x12 and G=0 → only idx 8 invalidated.
- GVMA with rs1=x0, rs2=x0 → FlushAllVirt at N+1, FenceDoneM at N+2, no EntryInvalidate.
- TLBBusy high at request for 3 cycles, then high at idx 10 for 2 cycles → idx 10 is held with no invalidate; FenceDoneM at N+38.
- GVMA with rs2=VMID 6 and rs1=0x1000 → every virtual VMID-6 entry is invalidated regardless of VPN; non-virtual entries are untouched.
- reset=0 during SCAN at idx 12 → next cycle IDLE, all outputs 0, no FenceDoneM; a new request then restarts from idx 0.

Source files
------------

// File: rtl/hfence_seq_pkg.sv
// rtl/hfence_seq_pkg.sv - shared types, widths and helpers for the HFENCE sequencer
package hfence_seq_pkg;

    // Minimal core configuration record; only XLEN is consumed here.
    typedef struct packed {
        logic [31:0] XLEN;
    } cvw_t;

    localparam cvw_t CVW_RV64 = '{XLEN: 32'd64};
    localparam cvw_t CVW_RV32 = '{XLEN: 32'd32};

    localparam int VMIDW_RV64 = 14;   // hgatp[57:44]
    localparam int VMIDW_RV32 = 7;    // hgatp[28:22]
    localparam int ASIDW_RV64 = 16;
    localparam int ASIDW_RV32 = 9;
    localparam int VPNW_RV64  = 27;   // Sv39 VA[38:12]
    localparam int VPNW_RV32  = 20;   // Sv32 VA[31:12]

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SCAN,
        FLUSH,
        DONE
    } hfence_state_t;

    function automatic int vmid_w(input int xlen);
        return (xlen == 64) ? VMIDW_RV64 : VMIDW_RV32;
    endfunction

    function automatic int asid_w(input int xlen);
        return (xlen == 64) ? ASIDW_RV64 : ASIDW_RV32;
    endfunction

    function automatic int vpn_w(input int xlen);
        return (xlen == 64) ? VPNW_RV64 : VPNW_RV32;
    endfunction

    // Bit position of the VMID field inside hgatp.
    function automatic int vmid_lsb(input int xlen);
        return (xlen == 64) ? 44 : 22;
    endfunction

endpackage

// File: rtl/hfence_seq_if.sv
// rtl/hfence_seq_if.sv - TLB inspect/invalidate port between fence sequencer and TLB
// Ports: TLBBusy and Entry* tags flow TLB -> sequencer; EntryIdx, EntryInvalidate
// and FlushAllVirt flow sequencer -> TLB. master = sequencer side, slave = TLB side.
interface hfence_seq_if #(
    parameter int IDXW  = 5,
    parameter int VMIDW = 14,
    parameter int ASIDW = 16,
    parameter int VPNW  = 27
);
    logic             TLBBusy;
    logic             EntryValid;
    logic             EntryVirt;
    logic             EntryGlobal;
    logic [VMIDW-1:0] EntryVMID;
    logic [ASIDW-1:0] EntryASID;
    logic [VPNW-1:0]  EntryVPN;
    logic [IDXW-1:0]  EntryIdx;
    logic             EntryInvalidate;
    logic             FlushAllVirt;

    modport master (
        input  TLBBusy, EntryValid, EntryVirt, EntryGlobal, EntryVMID, EntryASID, EntryVPN,
        output EntryIdx, EntryInvalidate, FlushAllVirt
    );

    modport slave (
        output TLBBusy, EntryValid, EntryVirt, EntryGlobal, EntryVMID, EntryASID, EntryVPN,
        input  EntryIdx, EntryInvalidate, FlushAllVirt
    );
endinterface

// File: rtl/hfence_match.sv
// rtl/hfence_match.sv - combinational HFENCE entry match rule
// Ports: fence operands (gvma, zero flags, vmid/asid/vpn) and one TLB entry's tags in;
// hit out when that entry must be invalidated.
module hfence_match #(
    parameter int VMIDW = 14,
    parameter int ASIDW = 16,
    parameter int VPNW  = 27
) (
    input  logic             gvma,
    input  logic             rs1_zero,
    input  logic             rs2_zero,
    input  logic [VMIDW-1:0] vmid,
    input  logic [ASIDW-1:0] asid,
    input  logic [VPNW-1:0]  vpn,
    input  logic             entry_valid,
    input  logic             entry_virt,
    input  logic             entry_global,
    input  logic [VMIDW-1:0] entry_vmid,
    input  logic [ASIDW-1:0] entry_asid,
    input  logic [VPNW-1:0]  entry_vpn,
    output logic             hit
);
    logic vmid_eq;
    logic vva_hit;
    logic gva_hit;

    assign vmid_eq = (entry_vmid == vmid);

    assign vva_hit = vmid_eq
                   & (rs1_zero | (entry_vpn == vpn))
                   & (rs2_zero | (~entry_global & (entry_asid == asid)));

    // GVMA ignores the guest-physical address: cached translations are combined
    // two-stage, so every entry of the VMID has to go.
    assign gva_hit = rs2_zero | vmid_eq;

    assign hit = entry_valid & entry_virt & (gvma ? gva_hit : vva_hit);
endmodule

// File: rtl/hfence_seq.sv
// rtl/hfence_seq.sv - HFENCE.VVMA/GVMA sequencer walking the TLB one entry per cycle
// Ports: clk, reset (sync, active-low); fence request, operands and hgatp in;
// tlb (master) inspects/invalidates entries; FenceStallM holds M, FenceDoneM pulses at end.
module hfence_seq
    import hfence_seq_pkg::*;
#(
    parameter cvw_t P       = CVW_RV64,
    parameter int   ENTRIES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              HFenceVVMAM,
    input  logic              HFenceGVMAM,
    input  logic [P.XLEN-1:0] FenceRs1M,
    input  logic [P.XLEN-1:0] FenceRs2M,
    input  logic              Rs1ZeroM,
    input  logic              Rs2ZeroM,
    input  logic [P.XLEN-1:0] HGATP_REGW,
    hfence_seq_if.master      tlb,
    output logic              FenceStallM,
    output logic              FenceDoneM
);
    localparam int XLEN  = int'(P.XLEN);
    localparam int IDXW  = $clog2(ENTRIES);
    localparam int VMIDW = vmid_w(XLEN);
    localparam int ASIDW = asid_w(XLEN);
    localparam int VPNW  = vpn_w(XLEN);
    localparam int VLSB  = vmid_lsb(XLEN);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(ENTRIES - 1);

    hfence_state_t    state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             gvma_q, gvma_d;
    logic             rs1z_q, rs1z_d;
    logic             rs2z_q, rs2z_d;
    logic [VPNW-1:0]  vpn_q, vpn_d;
    logic [ASIDW-1:0] asid_q, asid_d;
    logic [VMIDW-1:0] vmid_q, vmid_d;

    logic req;
    logic hit;
    logic unused_bits;

    assign req         = HFenceVVMAM | HFenceGVMAM;
    assign unused_bits = ^{FenceRs1M, FenceRs2M, HGATP_REGW};

    hfence_match #(
        .VMIDW (VMIDW),
        .ASIDW (ASIDW),
        .VPNW  (VPNW)
    ) u_match (
        .gvma         (gvma_q),
        .rs1_zero     (rs1z_q),
        .rs2_zero     (rs2z_q),
        .vmid         (vmid_q),
        .asid         (asid_q),
        .vpn          (vpn_q),
        .entry_valid  (tlb.EntryValid),
        .entry_virt   (tlb.EntryVirt),
        .entry_global (tlb.EntryGlobal),
        .entry_vmid   (tlb.EntryVMID),
        .entry_asid   (tlb.EntryASID),
        .entry_vpn    (tlb.EntryVPN),
        .hit          (hit)
    );

    always_comb begin
        state_d             = state_q;
        idx_d               = idx_q;
        gvma_d              = gvma_q;
        rs1z_d              = rs1z_q;
        rs2z_d              = rs2z_q;
        vpn_d               = vpn_q;
        asid_d              = asid_q;
        vmid_d              = vmid_q;
        FenceStallM         = 1'b0;
        FenceDoneM          = 1'b0;
        tlb.EntryInvalidate = 1'b0;
        tlb.FlushAllVirt    = 1'b0;

        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                if (req) begin
                    FenceStallM = 1'b1;
                    // GVMA has priority if both decode strobes are high.
                    gvma_d = HFenceGVMAM;
                    rs1z_d = Rs1ZeroM;
                    rs2z_d = Rs2ZeroM;
                    vpn_d  = FenceRs1M[12 +: VPNW];
                    asid_d = FenceRs2M[ASIDW-1:0];
                    vmid_d = HFenceGVMAM ? FenceRs2M[VMIDW-1:0] : HGATP_REGW[VLSB +: VMIDW];
                    if (HFenceGVMAM & Rs1ZeroM & Rs2ZeroM) begin
                        state_d = FLUSH;
                    end else if (tlb.TLBBusy) begin
                        state_d = WAIT;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            WAIT: begin
                FenceStallM = 1'b1;
                if (!tlb.TLBBusy) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                FenceStallM = 1'b1;
                // A TLB fill owns the entry array this cycle: hold index, no clears.
                if (!tlb.TLBBusy) begin
                    tlb.EntryInvalidate = hit;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                FenceStallM      = 1'b1;
                tlb.FlushAllVirt = 1'b1;
                state_d          = DONE;
            end
            DONE: begin
                FenceDoneM = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tlb.EntryIdx = idx_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            gvma_q  <= 1'b0;
            rs1z_q  <= 1'b0;
            rs2z_q  <= 1'b0;
            vpn_q   <= '0;
            asid_q  <= '0;
            vmid_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gvma_q  <= gvma_d;
            rs1z_q  <= rs1z_d;
            rs2z_q  <= rs2z_d;
            vpn_q   <= vpn_d;
            asid_q  <= asid_d;
            vmid_q  <= vmid_d;
        end
    end
endmodule

// File: tb/tb_hfence_seq.sv
// tb/tb_hfence_seq.sv - directed self-checking bench for hfence_seq
module tb_hfence_seq;
    import hfence_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        HFenceVVMAM, HFenceGVMAM;
    logic [63:0] FenceRs1M, FenceRs2M, HGATP_REGW;
    logic        Rs1ZeroM, Rs2ZeroM;
    logic        FenceStallM, FenceDoneM;
    logic        busy;

    logic        ent_valid  [32];
    logic        ent_virt   [32];
    logic        ent_global [32];
    logic [13:0] ent_vmid   [32];
    logic [15:0] ent_asid   [32];
    logic [26:0] ent_vpn    [32];

    int tests  = 0;
    int failed = 0;

    logic [31:0] got_mask;
    int got_done_k, got_flush_k, got_flush_cnt, got_first_idx;
    int got_busy_inval, got_hold, got_stall_done;

    hfence_seq_if #(.IDXW(5), .VMIDW(14), .ASIDW(16), .VPNW(27)) tlb_if ();

    assign tlb_if.TLBBusy     = busy;
    assign tlb_if.EntryValid  = ent_valid[tlb_if.EntryIdx];
    assign tlb_if.EntryVirt   = ent_virt[tlb_if.EntryIdx];
    assign tlb_if.EntryGlobal = ent_global[tlb_if.EntryIdx];
    assign tlb_if.EntryVMID   = ent_vmid[tlb_if.EntryIdx];
    assign tlb_if.EntryASID   = ent_asid[tlb_if.EntryIdx];
    assign tlb_if.EntryVPN    = ent_vpn[tlb_if.EntryIdx];

    hfence_seq #(.P(CVW_RV64), .ENTRIES(32)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .HFenceVVMAM (HFenceVVMAM),
        .HFenceGVMAM (HFenceGVMAM),
        .FenceRs1M   (FenceRs1M),
        .FenceRs2M   (FenceRs2M),
        .Rs1ZeroM    (Rs1ZeroM),
        .Rs2ZeroM    (Rs2ZeroM),
        .HGATP_REGW  (HGATP_REGW),
        .tlb         (tlb_if),
        .FenceStallM (FenceStallM),
        .FenceDoneM  (FenceDoneM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_entries();
        for (int i = 0; i < 32; i++) begin
            ent_valid[i] = 1'b0; ent_virt[i] = 1'b0; ent_global[i] = 1'b0;
            ent_vmid[i] = '0; ent_asid[i] = '0; ent_vpn[i] = '0;
        end
    endtask

    task automatic set_entry(input int i, input logic virt, input logic g,
                             input int vmid, input int asid, input int vpn);
        ent_valid[i] = 1'b1; ent_virt[i] = virt; ent_global[i] = g;
        ent_vmid[i] = 14'(vmid); ent_asid[i] = 16'(asid); ent_vpn[i] = 27'(vpn);
    endtask

    // Drives one request at a negedge; hgatp carries mode/PPN noise around the VMID.
    task automatic drive_req(input logic gvma, input logic [63:0] rs1, input logic [63:0] rs2,
                             input logic rs1z, input logic rs2z, input int hv, input logic bsy);
        @(negedge clk);
        HFenceVVMAM = ~gvma;
        HFenceGVMAM = gvma;
        FenceRs1M   = rs1;
        FenceRs2M   = rs2;
        Rs1ZeroM    = rs1z;
        Rs2ZeroM    = rs2z;
        HGATP_REGW  = 64'h8000_0000_0000_1234 | (64'(hv) << 44);
        busy        = bsy;
        #1;
        check("stall_at_request", FenceStallM, 1'b1);
    endtask

    task automatic drop_req();
        HFenceVVMAM = 0; HFenceGVMAM = 0; FenceRs1M = 0; FenceRs2M = 0;
        Rs1ZeroM = 0; Rs2ZeroM = 0;
    endtask

    // k counts cycles after the request cycle N (k=1 is N+1).
    task automatic run_fence(input logic gvma, input logic [63:0] rs1, input logic [63:0] rs2,
                             input logic rs1z, input logic rs2z, input int hv,
                             input int pre_busy, input int busy_idx, input int busy_len);
        int left;
        left = busy_len;
        got_mask = '0; got_done_k = -1; got_flush_k = -1; got_flush_cnt = 0;
        got_first_idx = -1; got_busy_inval = 0; got_hold = 0; got_stall_done = -1;
        drive_req(gvma, rs1, rs2, rs1z, rs2z, hv, pre_busy > 0);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) drop_req();
            busy = 1'b0;
            if (k < pre_busy) begin
                busy = 1'b1;
            end else if (left > 0 && FenceStallM && int'(tlb_if.EntryIdx) == busy_idx) begin
                busy = 1'b1;
                left--;
            end
            #1;
            if (k == 1) got_first_idx = int'(tlb_if.EntryIdx);
            if (tlb_if.EntryInvalidate) got_mask = got_mask | (32'd1 << tlb_if.EntryIdx);
            if (busy && tlb_if.EntryInvalidate) got_busy_inval++;
            if (FenceStallM && int'(tlb_if.EntryIdx) == busy_idx) got_hold++;
            if (tlb_if.FlushAllVirt) begin
                got_flush_cnt++;
                got_flush_k = k;
            end
            if (FenceDoneM) begin
                got_done_k = k;
                got_stall_done = int'(FenceStallM);
                break;
            end
        end
        busy = 1'b0;
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; busy = 1'b0;
        drop_req();
        HGATP_REGW = '0;
        clear_entries();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_idx", 64'(tlb_if.EntryIdx), 0);
        check("rst_inval", tlb_if.EntryInvalidate, 0);
        check("rst_flush", tlb_if.FlushAllVirt, 0);
        check("rst_stall", FenceStallM, 0);
        check("rst_done", FenceDoneM, 0);
        rst_n = 1'b1;

        // VVMA, rs1=rs2=x0, VMID 5
        clear_entries();
        set_entry(3, 1, 0, 5, 1, 7);
        set_entry(9, 1, 1, 5, 2, 8);
        set_entry(4, 1, 0, 6, 1, 7);
        set_entry(5, 0, 0, 5, 1, 7);
        run_fence(0, 0, 0, 1, 1, 5, 0, 99, 0);
        check("t1_mask", 64'(got_mask), 64'h208);
        check("t1_done_k", 64'(got_done_k), 33);
        check("t1_first_idx", 64'(got_first_idx), 0);
        check("t1_flush", 64'(got_flush_cnt), 0);
        check("t1_stall_done", 64'(got_stall_done), 0);
        @(negedge clk); #1;
        check("t1_idle_stall", FenceStallM, 0);
        check("t1_idle_done", FenceDoneM, 0);

        // VVMA with ASID 0x12: global entry 7 survives, 8 goes, 9 wrong ASID
        clear_entries();
        set_entry(7, 1, 1, 5, 'h12, 0);
        set_entry(8, 1, 0, 5, 'h12, 0);
        set_entry(9, 1, 0, 5, 'h13, 0);
        run_fence(0, 0, 64'h12, 1, 0, 5, 0, 99, 0);
        check("t2_mask", 64'(got_mask), 64'h100);
        check("t2_done_k", 64'(got_done_k), 33);

        // GVMA rs1=rs2=x0: bulk flush
        clear_entries();
        set_entry(3, 1, 0, 5, 0, 0);
        run_fence(1, 0, 0, 1, 1, 5, 0, 99, 0);
        check("t3_mask", 64'(got_mask), 0);
        check("t3_flush_k", 64'(got_flush_k), 1);
        check("t3_flush_cnt", 64'(got_flush_cnt), 1);
        check("t3_done_k", 64'(got_done_k), 2);

        // Busy 3 cycles at request, then 2 cycles at idx 10
        clear_entries();
        set_entry(3, 1, 0, 5, 0, 0);
        set_entry(10, 1, 0, 5, 0, 0);
        run_fence(0, 0, 0, 1, 1, 5, 3, 10, 2);
        check("t4_mask", 64'(got_mask), 64'h408);
        check("t4_done_k", 64'(got_done_k), 38);
        check("t4_busy_inval", 64'(got_busy_inval), 0);
        check("t4_hold_cycles", 64'(got_hold), 3);

        // GVMA VMID 6, rs1=0x1000 ignored
        clear_entries();
        set_entry(4, 1, 0, 6, 0, 'h55);
        set_entry(11, 1, 1, 6, 3, 1);
        set_entry(12, 1, 0, 6, 0, 'h77);
        set_entry(13, 0, 0, 6, 0, 1);
        set_entry(14, 1, 0, 7, 0, 1);
        run_fence(1, 64'h1000, 64'h6, 0, 0, 9, 0, 99, 0);
        check("t5_mask", 64'(got_mask), 64'h1810);
        check("t5_done_k", 64'(got_done_k), 33);
        check("t5_flush", 64'(got_flush_cnt), 0);

        // VVMA address match, rs1=0x3000 (VPN 3)
        clear_entries();
        set_entry(2, 1, 0, 5, 0, 3);
        set_entry(6, 1, 0, 5, 0, 4);
        set_entry(20, 1, 0, 6, 0, 3);
        run_fence(0, 64'h3000, 0, 0, 1, 5, 0, 99, 0);
        check("t6_mask", 64'(got_mask), 64'h4);

        // GVMA wins when both strobes are high: VMID from rs2, not hgatp
        clear_entries();
        set_entry(1, 1, 0, 6, 0, 0);
        set_entry(2, 1, 0, 5, 0, 0);
        drive_req(1, 64'h1000, 64'h6, 0, 0, 5, 0);
        HFenceVVMAM = 1'b1;
        got_mask = '0; got_done_k = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) drop_req();
            #1;
            if (tlb_if.EntryInvalidate) got_mask = got_mask | (32'd1 << tlb_if.EntryIdx);
            if (FenceDoneM) begin
                got_done_k = k;
                break;
            end
        end
        check("t7_both_mask", 64'(got_mask), 64'h2);
        check("t7_both_done", 64'(got_done_k), 33);

        // Reset during SCAN at idx 12
        clear_entries();
        set_entry(12, 1, 0, 5, 0, 0);
        set_entry(20, 1, 0, 5, 0, 0);
        drive_req(0, 0, 0, 1, 1, 5, 0);
        cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) drop_req();
            #1;
            if (tlb_if.EntryIdx == 5'd12) begin
                cnt = k;
                break;
            end
        end
        check("t8_reached_idx12", 64'(cnt), 13);
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("t8_rst_idx", 64'(tlb_if.EntryIdx), 0);
        check("t8_rst_inval", tlb_if.EntryInvalidate, 0);
        check("t8_rst_flush", tlb_if.FlushAllVirt, 0);
        check("t8_rst_stall", FenceStallM, 0);
        check("t8_rst_done", FenceDoneM, 0);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (FenceDoneM || FenceStallM) cnt++;
        end
        check("t8_no_done_after_rst", 64'(cnt), 0);
        run_fence(0, 0, 0, 1, 1, 5, 0, 99, 0);
        check("t8_restart_first_idx", 64'(got_first_idx), 0);
        check("t8_restart_mask", 64'(got_mask), 64'h0010_1000);
        check("t8_restart_done_k", 64'(got_done_k), 33);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
